// File: rtl/ahb_apb_bridge_if.sv
// AHB-Lite slave side plus APB master side of the bridge, bundled for port hookup.
// Use slave on the bridge, master on whatever drives the AHB side and models the APB slaves.
interface ahb_apb_bridge_if #(
  parameter int NSLV    = 4,
  parameter int PADDR_W = 16
);
  logic                 HSEL;
  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [31:0]          HWDATA;
  logic                 HREADY;
  logic                 HREADYOUT;
  logic [31:0]          HRDATA;
  logic                 HRESP;
  logic [PADDR_W-1:0]   PADDR;
  logic [NSLV-1:0]      PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [31:0]          PWDATA;
  logic [NSLV*32-1:0]   PRDATA;
  logic [NSLV-1:0]      PREADY;
  logic [NSLV-1:0]      PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP+ACCESS per accepted AHB transfer.
// Latency 2 wait states with a zero-wait slave; HREADYOUT stays low while PREADY is low.
module ahb_apb_bridge #(
  parameter int NSLV     = 4,
  parameter int PSEL_LSB = 16,
  parameter int PADDR_W  = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_apb_bridge_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;

  state_t               state_q, state_d;
  logic [PADDR_W-1:0]   addr_q;
  logic                 write_q;
  logic [3:0]           idx_q;
  logic [31:0]          hrdata_q;

  logic [3:0]           haddr_idx;
  logic                 idx_ok;
  logic                 can_accept;
  logic                 accept;
  logic                 rd_load;
  logic                 sel_ready;
  logic                 sel_err;
  logic [31:0]          sel_rdata;
  logic [NSLV-1:0]      psel_onehot;

  logic                 hreadyout_c;
  logic                 hresp_c;
  logic [NSLV-1:0]      psel_c;
  logic                 penable_c;
  logic [31:0]          pwdata_c;

  // Upper address bits and HTRANS[0] carry no meaning for this bridge.
  logic                 unused_bits;
  assign unused_bits = ^{bus.HADDR, bus.HTRANS[0]};

  assign haddr_idx  = bus.HADDR[PSEL_LSB+3:PSEL_LSB];
  assign idx_ok     = ({1'b0, haddr_idx} < 5'(NSLV));
  assign can_accept = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR2);
  assign accept     = can_accept && bus.HSEL && bus.HTRANS[1] && bus.HREADY;

  always_comb begin
    sel_ready   = 1'b0;
    sel_err     = 1'b0;
    sel_rdata   = 32'h0;
    psel_onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready      = bus.PREADY[i];
        sel_err        = bus.PSLVERR[i];
        sel_rdata      = bus.PRDATA[32*i +: 32];
        psel_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_c = 1'b1;
    hresp_c     = 1'b0;
    psel_c      = '0;
    penable_c   = 1'b0;
    pwdata_c    = 32'h0;
    rd_load     = 1'b0;
    case (state_q)
      IDLE, DONE, ERR2: begin
        hresp_c = (state_q == ERR2);
        if (accept) state_d = idx_ok ? SETUP : ERR1;
        else        state_d = IDLE;
      end
      SETUP: begin
        hreadyout_c = 1'b0;
        psel_c      = psel_onehot;
        pwdata_c    = write_q ? bus.HWDATA : 32'h0;
        state_d     = ACCESS;
      end
      ACCESS: begin
        hreadyout_c = 1'b0;
        psel_c      = psel_onehot;
        penable_c   = 1'b1;
        pwdata_c    = write_q ? bus.HWDATA : 32'h0;
        if (sel_ready) begin
          state_d = sel_err ? ERR1 : DONE;
          rd_load = !sel_err && !write_q;
        end
      end
      ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = 1'b1;
        state_d     = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/direction are captured even for an out-of-range index so PADDR tracks the last accept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= 4'h0;
      hrdata_q <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= bus.HADDR[PADDR_W-1:0];
        write_q <= bus.HWRITE;
        idx_q   <= haddr_idx;
      end
      if (rd_load) hrdata_q <= sel_rdata;
    end
  end

  assign bus.HREADYOUT = hreadyout_c;
  assign bus.HRESP     = hresp_c;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PSEL      = psel_c;
  assign bus.PENABLE   = penable_c;
  assign bus.PWDATA    = pwdata_c;
  assign bus.PADDR     = addr_q;
  assign bus.PWRITE    = write_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: directed scenarios plus randomized transfers
// checked cycle by cycle against a phase-level model of one AHB transfer.
module tb_ahb_apb_bridge;
  localparam int NSLV     = 4;
  localparam int PSEL_LSB = 16;
  localparam int PADDR_W  = 16;
  localparam int MAXT     = 40;

  typedef struct packed {
    logic [NSLV-1:0]    psel;
    logic               penable;
    logic               hready;
    logic               hresp;
    logic               pwrite;
    logic [PADDR_W-1:0] paddr;
    logic [31:0]        pwdata;
  } obs_t;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_apb_bridge_if #(.NSLV(NSLV), .PADDR_W(PADDR_W)) bus ();

  ahb_apb_bridge #(.NSLV(NSLV), .PSEL_LSB(PSEL_LSB), .PADDR_W(PADDR_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  // The bridge is the only slave on this bus, so bus-level HREADY follows it.
  assign bus.HREADY = bus.HREADYOUT;

  // APB slave models: PREADY rises after cfg_delay cycles of ACCESS.
  logic [31:0] cfg_rdata [NSLV];
  logic [7:0]  cfg_delay [NSLV];
  logic        cfg_err   [NSLV];
  logic [7:0]  wcnt      [NSLV];

  always_comb begin
    for (int i = 0; i < NSLV; i++) begin
      bus.PRDATA[32*i +: 32] = cfg_rdata[i];
      bus.PREADY[i]          = (wcnt[i] >= cfg_delay[i]);
      bus.PSLVERR[i]         = cfg_err[i];
    end
  end

  always @(posedge HCLK) begin
    for (int i = 0; i < NSLV; i++) begin
      if (bus.PSEL[i] && bus.PENABLE && !bus.PREADY[i]) wcnt[i] <= wcnt[i] + 8'd1;
      else                                              wcnt[i] <= 8'd0;
    end
  end

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] hrdata_exp = 32'h0;
  obs_t        t_obs [MAXT];
  int          t_n;
  bit          t_timeout;

  // Expected bus view in cycle k after the accepting edge of one transfer.
  function automatic obs_t model(int k, logic [31:0] addr, logic wr, int d, logic err, logic [31:0] wd);
    int   idx = int'(addr[PSEL_LSB +: 4]);
    obs_t e   = '0;
    e.pwrite = wr;
    e.paddr  = addr[PADDR_W-1:0];
    e.hready = 1'b1;
    if (idx >= NSLV) begin
      e.hresp  = 1'b1;
      e.hready = (k == 1);
    end else if (k <= d + 1) begin
      e.psel    = NSLV'(1 << idx);
      e.penable = (k != 0);
      e.hready  = 1'b0;
      e.pwdata  = wr ? wd : 32'h0;
    end else if (err) begin
      e.hresp  = 1'b1;
      e.hready = (k == d + 3);
    end
    return e;
  endfunction

  function automatic int model_len(logic [31:0] addr, int d, logic err);
    if (int'(addr[PSEL_LSB +: 4]) >= NSLV) return 2;
    return 2 + d + (err ? 2 : 1);
  endfunction

  task automatic start_addr(input logic [31:0] a, input logic w);
    bus.HSEL   = 1'b1;
    bus.HADDR  = a;
    bus.HTRANS = 2'b10;
    bus.HWRITE = w;
  endtask

  // Drives the data phase and records every cycle up to and including the HREADYOUT=1 cycle.
  task automatic run_data(input logic [31:0] wd);
    t_n       = 0;
    t_timeout = 1'b1;
    for (int k = 0; k < MAXT; k++) begin
      @(negedge HCLK);
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWDATA = wd;
      #1;
      t_obs[k] = '{psel: bus.PSEL, penable: bus.PENABLE, hready: bus.HREADYOUT, hresp: bus.HRESP,
                   pwrite: bus.PWRITE, paddr: bus.PADDR, pwdata: bus.PWDATA};
      t_n = k + 1;
      if (bus.HREADYOUT) begin
        t_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_slave(input int i, input logic [31:0] rd, input int d, input logic e);
    cfg_rdata[i] = rd;
    cfg_delay[i] = 8'(d);
    cfg_err[i]   = e;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PENABLE, bus.PWRITE} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctl got %b exp 1000", {bus.HREADYOUT, bus.HRESP, bus.PENABLE, bus.PWRITE});
    end
    checks++;
    if (bus.PSEL !== '0) begin
      failures++; $display("FAIL reset_psel got %b exp 0", bus.PSEL);
    end
    checks++;
    if ({bus.HRDATA, bus.PWDATA, bus.PADDR} !== '0) begin
      failures++; $display("FAIL reset_data got %h %h %h exp 0", bus.HRDATA, bus.PWDATA, bus.PADDR);
    end
  endtask

  task automatic test_write();
    logic [31:0] a  = 32'h4001_0008;
    logic [31:0] wd = 32'hA5A5_5A5A;
    set_slave(1, 32'h0, 0, 1'b0);
    start_addr(a, 1'b1);
    run_data(wd);
    checks++;
    if (t_timeout || t_n != model_len(a, 0, 1'b0)) begin
      failures++; $display("FAIL write_len got %0d exp %0d", t_n, model_len(a, 0, 1'b0));
    end
    for (int k = 0; k < t_n; k++) begin
      checks++;
      if (t_obs[k] !== model(k, a, 1'b1, 0, 1'b0, wd)) begin
        failures++; $display("FAIL write cyc%0d got %h exp %h", k, t_obs[k], model(k, a, 1'b1, 0, 1'b0, wd));
      end
    end
  endtask

  task automatic test_read_wait();
    logic [31:0] a = 32'h4003_0010;
    int n_access = 0;
    set_slave(3, 32'h1234_5678, 3, 1'b0);
    start_addr(a, 1'b0);
    run_data(32'hFFFF_FFFF);
    hrdata_exp = 32'h1234_5678;
    checks++;
    if (t_timeout || t_n != model_len(a, 3, 1'b0)) begin
      failures++; $display("FAIL read_wait_len got %0d exp %0d", t_n, model_len(a, 3, 1'b0));
    end
    for (int k = 0; k < t_n; k++) begin
      n_access += int'(t_obs[k].penable);
      checks++;
      if (t_obs[k] !== model(k, a, 1'b0, 3, 1'b0, 32'hFFFF_FFFF)) begin
        failures++; $display("FAIL read_wait cyc%0d got %h exp %h", k, t_obs[k], model(k, a, 1'b0, 3, 1'b0, 32'hFFFF_FFFF));
      end
    end
    checks++;
    if (n_access != 4) begin
      failures++; $display("FAIL read_wait_access got %0d exp 4", n_access);
    end
    checks++;
    if (bus.HRDATA !== hrdata_exp) begin
      failures++; $display("FAIL read_wait_hrdata got %h exp %h", bus.HRDATA, hrdata_exp);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] a = 32'h4002_0004;
    set_slave(2, 32'hDEAD_BEEF, 0, 1'b1);
    start_addr(a, 1'b0);
    run_data(32'h0);
    checks++;
    if (t_timeout || t_n != model_len(a, 0, 1'b1)) begin
      failures++; $display("FAIL slverr_len got %0d exp %0d", t_n, model_len(a, 0, 1'b1));
    end
    for (int k = 0; k < t_n; k++) begin
      checks++;
      if (t_obs[k] !== model(k, a, 1'b0, 0, 1'b1, 32'h0)) begin
        failures++; $display("FAIL slverr cyc%0d got %h exp %h", k, t_obs[k], model(k, a, 1'b0, 0, 1'b1, 32'h0));
      end
    end
    checks++;
    if (bus.HRDATA !== hrdata_exp) begin
      failures++; $display("FAIL slverr_hrdata got %h exp %h", bus.HRDATA, hrdata_exp);
    end
    set_slave(2, 32'hDEAD_BEEF, 0, 1'b0);
  endtask

  task automatic test_bad_idx();
    logic [31:0] a = 32'h4007_0000;
    start_addr(a, 1'b1);
    run_data(32'h1111_2222);
    checks++;
    if (t_timeout || t_n != 2) begin
      failures++; $display("FAIL bad_idx_len got %0d exp 2", t_n);
    end
    for (int k = 0; k < t_n; k++) begin
      checks++;
      if (t_obs[k] !== model(k, a, 1'b1, 0, 1'b0, 32'h1111_2222)) begin
        failures++; $display("FAIL bad_idx cyc%0d got %h exp %h", k, t_obs[k], model(k, a, 1'b1, 0, 1'b0, 32'h1111_2222));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0 = 32'h4000_0004;
    logic [31:0] a1 = 32'h4001_0020;
    set_slave(0, 32'h0, 0, 1'b0);
    set_slave(1, 32'h0BAD_CAFE, 0, 1'b0);
    start_addr(a0, 1'b1);
    run_data(32'h7777_8888);
    start_addr(a1, 1'b0);
    run_data(32'h0);
    hrdata_exp = 32'h0BAD_CAFE;
    checks++;
    if (t_timeout || t_n != 3) begin
      failures++; $display("FAIL b2b_len got %0d exp 3", t_n);
    end
    for (int k = 0; k < t_n; k++) begin
      checks++;
      if (t_obs[k] !== model(k, a1, 1'b0, 0, 1'b0, 32'h0)) begin
        failures++; $display("FAIL b2b cyc%0d got %h exp %h", k, t_obs[k], model(k, a1, 1'b0, 0, 1'b0, 32'h0));
      end
    end
    checks++;
    if (bus.HRDATA !== hrdata_exp) begin
      failures++; $display("FAIL b2b_hrdata got %h exp %h", bus.HRDATA, hrdata_exp);
    end
    // Selected-but-idle/busy and unselected-nonseq cycles must not start APB traffic.
    for (int k = 0; k < 6; k++) begin
      bus.HADDR  = 32'h4001_0000;
      bus.HSEL   = (k < 4);
      bus.HTRANS = (k < 2) ? 2'b00 : (k < 4) ? 2'b01 : 2'b10;
      @(negedge HCLK);
      #1;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== {{NSLV{1'b0}}, 3'b010}) begin
        failures++;
        $display("FAIL no_xfer cyc%0d got %b exp %b", k, {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP}, {{NSLV{1'b0}}, 3'b010});
      end
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a = 32'h4001_0044;
    set_slave(1, 32'h5555_AAAA, 5, 1'b0);
    start_addr(32'h4001_0040, 1'b1);
    @(negedge HCLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = 32'hCAFE_F00D;
    @(negedge HCLK);
    #1;
    checks++;
    if ({bus.PENABLE, bus.PWDATA} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL pre_reset_access got %b %h exp 1 cafef00d", bus.PENABLE, bus.PWDATA);
    end
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWDATA, bus.HREADYOUT, bus.HRESP} !== {{NSLV{1'b0}}, 1'b0, 32'h0, 2'b10}) begin
      failures++;
      $display("FAIL mid_reset got %b %b %h %b %b exp 0 0 0 1 0", bus.PSEL, bus.PENABLE, bus.PWDATA, bus.HREADYOUT, bus.HRESP);
    end
    hrdata_exp = 32'h0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    set_slave(1, 32'h5555_AAAA, 0, 1'b0);
    start_addr(a, 1'b0);
    run_data(32'h0);
    hrdata_exp = 32'h5555_AAAA;
    checks++;
    if (t_timeout || t_n != 3) begin
      failures++; $display("FAIL post_reset_len got %0d exp 3", t_n);
    end
    for (int k = 0; k < t_n; k++) begin
      checks++;
      if (t_obs[k] !== model(k, a, 1'b0, 0, 1'b0, 32'h0)) begin
        failures++; $display("FAIL post_reset cyc%0d got %h exp %h", k, t_obs[k], model(k, a, 1'b0, 0, 1'b0, 32'h0));
      end
    end
    checks++;
    if (bus.HRDATA !== hrdata_exp) begin
      failures++; $display("FAIL post_reset_hrdata got %h exp %h", bus.HRDATA, hrdata_exp);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          idx = $urandom_range(0, 7);
      int          d   = $urandom_range(0, 3);
      logic        wr  = 1'($urandom);
      logic        err = ($urandom_range(0, 3) == 0);
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      logic [31:0] a   = {8'h40, 4'h0, 4'(idx), 16'($urandom)};
      int          gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        repeat (gap) @(negedge HCLK);
        #1;
      end
      if (idx < NSLV) set_slave(idx, rd, d, err);
      start_addr(a, wr);
      run_data(wd);
      if (idx < NSLV && !err && !wr) hrdata_exp = rd;
      checks++;
      if (t_timeout || t_n != model_len(a, d, err)) begin
        failures++; $display("FAIL rand%0d_len got %0d exp %0d", n, t_n, model_len(a, d, err));
      end
      for (int k = 0; k < t_n; k++) begin
        checks++;
        if (t_obs[k] !== model(k, a, wr, d, err, wd)) begin
          failures++; $display("FAIL rand%0d cyc%0d got %h exp %h", n, k, t_obs[k], model(k, a, wr, d, err, wd));
        end
      end
      checks++;
      if (bus.HRDATA !== hrdata_exp) begin
        failures++; $display("FAIL rand%0d_hrdata got %h exp %h", n, bus.HRDATA, hrdata_exp);
      end
    end
  endtask

  initial begin
    bus.HSEL   = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HWDATA = 32'h0;
    for (int i = 0; i < NSLV; i++) set_slave(i, 32'h0, 0, 1'b0);
    #2 HRESETn = 1'b0;
    #1;
    test_reset();
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_bad_idx();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
